// File: rtl/orb_pkg.sv
// Shared ORB pipeline types: window state encoding, default geometry, coordinate type.
package orb_pkg;
  localparam int LUMA_BITS_DEF  = 8;
  localparam int WINDOW_DEF     = 37;
  localparam int COORD_BITS_DEF = 16;

  typedef enum logic [1:0] {FILLING, READY, FROZEN} orb_win_state_t;

  typedef logic [COORD_BITS_DEF-1:0] coord_t;
endpackage

// File: rtl/orb_window_buffer_if.sv
// Column-in / pixel-read bundle for the ORB sliding patch window.
interface orb_window_buffer_if #(
  parameter int LUMA_BITS  = 8,
  parameter int WINDOW     = 37,
  parameter int READ_PORTS = 2,
  parameter int COORD_BITS = 16
);
  localparam int AW = $clog2(WINDOW);
  localparam int FW = $clog2(WINDOW + 1);

  logic [WINDOW-1:0][LUMA_BITS-1:0] in_col;
  logic                             in_valid;
  logic [COORD_BITS-1:0]            in_x;
  logic [COORD_BITS-1:0]            in_y;
  logic                             in_freeze;
  logic                             in_release;
  logic                             in_flush;
  logic                             in_rd_valid;
  logic [READ_PORTS-1:0][AW-1:0]    in_rd_row;
  logic [READ_PORTS-1:0][AW-1:0]    in_rd_col;

  logic [READ_PORTS-1:0][LUMA_BITS-1:0] out_rd_data;
  logic                                 out_rd_valid;
  logic                                 out_window_ready;
  logic                                 out_accepting_input;
  logic                                 out_frozen;
  logic [COORD_BITS-1:0]                out_feature_x;
  logic [COORD_BITS-1:0]                out_feature_y;
  logic [FW-1:0]                        out_fill_count;

  modport master (
    output in_col, in_valid, in_x, in_y, in_freeze, in_release, in_flush,
           in_rd_valid, in_rd_row, in_rd_col,
    input  out_rd_data, out_rd_valid, out_window_ready, out_accepting_input,
           out_frozen, out_feature_x, out_feature_y, out_fill_count
  );

  modport slave (
    input  in_col, in_valid, in_x, in_y, in_freeze, in_release, in_flush,
           in_rd_valid, in_rd_row, in_rd_col,
    output out_rd_data, out_rd_valid, out_window_ready, out_accepting_input,
           out_frozen, out_feature_x, out_feature_y, out_fill_count
  );
endinterface

// File: rtl/orb_window_read_port.sv
// One registered 2-D pixel mux over the window; out-of-range or disabled reads return 0.
module orb_window_read_port
  import orb_pkg::*;
#(
  parameter int LUMA_BITS = LUMA_BITS_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  localparam int AW       = $clog2(WINDOW)
) (
  input  logic                                         clk,
  input  logic                                         in_reset_n,
  input  logic [WINDOW-1:0][WINDOW-1:0][LUMA_BITS-1:0] pix,
  input  logic                                         en,
  input  logic [AW-1:0]                                row,
  input  logic [AW-1:0]                                col,
  output logic [LUMA_BITS-1:0]                         data
);
  localparam logic [AW-1:0] LAST = AW'(WINDOW - 1);

  logic                 hit;
  logic [LUMA_BITS-1:0] sel;

  assign hit = en && (row <= LAST) && (col <= LAST);

  always_comb begin
    sel = '0;
    if (hit) sel = pix[col][row];
  end

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) data <= '0;
    else             data <= sel;
  end
endmodule

// File: rtl/orb_window_buffer.sv
// Sliding WINDOW x WINDOW luma patch with freeze/release/flush and multi-port 1-cycle reads.
module orb_window_buffer
  import orb_pkg::*;
#(
  parameter int LUMA_BITS  = LUMA_BITS_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int READ_PORTS = 2,
  parameter int COORD_BITS = COORD_BITS_DEF
) (
  input  logic                clk,
  input  logic                in_reset_n,
  orb_window_buffer_if.slave  bus
);
  localparam int FW = $clog2(WINDOW + 1);
  localparam logic [FW-1:0]         FULL = FW'(WINDOW);
  localparam logic [COORD_BITS-1:0] HALF = COORD_BITS'((WINDOW - 1) / 2);

  orb_win_state_t state, state_nxt;
  logic [WINDOW-1:0][WINDOW-1:0][LUMA_BITS-1:0] pix;
  logic [FW-1:0]         fill;
  logic [COORD_BITS-1:0] newest_x, newest_y, feat_x, feat_y;
  logic                  accepting, xfer, freeze_take, rd_en, rd_vld_q;

  assign xfer        = bus.in_valid && accepting && !bus.in_flush;
  assign freeze_take = (state == READY) && bus.in_freeze && !bus.in_flush;
  assign rd_en       = bus.in_rd_valid && (state != FILLING);

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) state <= FILLING;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.in_flush) begin
      state_nxt = FILLING;
    end else begin
      case (state)
        FILLING: if (xfer && fill == FULL - 1'b1) state_nxt = READY;
        READY:   if (bus.in_freeze)               state_nxt = FROZEN;
        FROZEN:  if (bus.in_release)              state_nxt = READY;
        default:                                  state_nxt = FILLING;
      endcase
    end
  end

  always_comb begin
    accepting = (state != FROZEN);
    bus.out_accepting_input = accepting;
    bus.out_window_ready    = (state == READY);
    bus.out_frozen          = (state == FROZEN);
  end

  // Pixel storage carries no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int c = 0; c < WINDOW - 1; c++) pix[c] <= pix[c+1];
      pix[WINDOW-1] <= bus.in_col;
    end
  end

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      fill     <= '0;
      newest_x <= '0;
      newest_y <= '0;
      feat_x   <= '0;
      feat_y   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (bus.in_flush)             fill <= '0;
      else if (xfer && fill != FULL) fill <= fill + 1'b1;
      if (xfer) begin
        newest_x <= bus.in_x;
        newest_y <= bus.in_y;
      end
      // A column arriving with the freeze is part of the captured patch.
      if (freeze_take) begin
        feat_x <= (xfer ? bus.in_x : newest_x) - HALF;
        feat_y <= xfer ? bus.in_y : newest_y;
      end
    end
  end

  assign bus.out_fill_count = fill;
  assign bus.out_feature_x  = feat_x;
  assign bus.out_feature_y  = feat_y;
  assign bus.out_rd_valid   = rd_vld_q;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    orb_window_read_port #(
      .LUMA_BITS (LUMA_BITS),
      .WINDOW    (WINDOW)
    ) u_port (
      .clk        (clk),
      .in_reset_n (in_reset_n),
      .pix        (pix),
      .en         (rd_en),
      .row        (bus.in_rd_row[p]),
      .col        (bus.in_rd_col[p]),
      .data       (bus.out_rd_data[p])
    );
  end
endmodule

// File: tb/tb_orb_window_buffer.sv
// Directed bench for orb_window_buffer: fill, reads, freeze/release, flush, async reset.
module tb_orb_window_buffer;
  import orb_pkg::*;

  localparam int W = 37;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  orb_window_buffer_if #(.LUMA_BITS(8), .WINDOW(W), .READ_PORTS(2), .COORD_BITS(16)) bus ();

  orb_window_buffer #(.LUMA_BITS(8), .WINDOW(W), .READ_PORTS(2), .COORD_BITS(16)) dut (
    .clk        (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    bus.in_valid    = 1'b0;
    bus.in_freeze   = 1'b0;
    bus.in_release  = 1'b0;
    bus.in_flush    = 1'b0;
    bus.in_rd_valid = 1'b0;
    bus.in_rd_row   = '0;
    bus.in_rd_col   = '0;
  endtask

  // Inputs are set after a falling edge, taken on the rising edge, outputs sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    clear();
  endtask

  task automatic load_col(input int base, input int x, input int y);
    for (int r = 0; r < W; r++) bus.in_col[r] = 8'(r + base);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'(x);
    bus.in_y     = 16'(y);
  endtask

  task automatic rd(input int p, input int r, input int c);
    bus.in_rd_valid  = 1'b1;
    bus.in_rd_row[p] = 6'(r);
    bus.in_rd_col[p] = 6'(c);
  endtask

  task automatic fill_window(input logic freeze_on_last);
    for (int k = 0; k < W - 1; k++) begin
      load_col(k, k, 50);
      step();
    end
    check("fill36_count", 32'(bus.out_fill_count), 36);
    check("fill36_ready", 32'(bus.out_window_ready), 0);
    load_col(W - 1, 100, 50);
    bus.in_freeze = freeze_on_last;
    step();
    check("fill37_ready", 32'(bus.out_window_ready), 1);
    check("fill37_count", 32'(bus.out_fill_count), 37);
    check("fill37_frozen", 32'(bus.out_frozen), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear();
    bus.in_col = '0;
    bus.in_x   = '0;
    bus.in_y   = '0;
    @(negedge clk);
    check("rst_rd_data0", 32'(bus.out_rd_data[0]), 0);
    check("rst_rd_data1", 32'(bus.out_rd_data[1]), 0);
    check("rst_rd_valid", 32'(bus.out_rd_valid), 0);
    check("rst_ready", 32'(bus.out_window_ready), 0);
    check("rst_accepting", 32'(bus.out_accepting_input), 1);
    check("rst_frozen", 32'(bus.out_frozen), 0);
    check("rst_fx", 32'(bus.out_feature_x), 0);
    check("rst_fy", 32'(bus.out_feature_y), 0);
    check("rst_fill", 32'(bus.out_fill_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Freeze while filling is ignored.
    load_col(0, 0, 50);
    bus.in_freeze = 1'b1;
    step();
    check("fill_freeze_ignored", 32'(bus.out_frozen), 0);
    check("fill_count1", 32'(bus.out_fill_count), 1);
    rd(0, 0, 0);
    step();
    check("fill_rd_valid", 32'(bus.out_rd_valid), 0);
    check("fill_rd_data", 32'(bus.out_rd_data[0]), 0);
    for (int k = 1; k < W - 1; k++) begin
      load_col(k, k, 50);
      step();
    end
    check("pre_ready", 32'(bus.out_window_ready), 0);
    load_col(W - 1, 100, 50);
    step();
    check("ready_rise", 32'(bus.out_window_ready), 1);
    check("ready_fill", 32'(bus.out_fill_count), 37);

    rd(0, 0, 0); rd(1, 36, 36);
    step();
    check("rd_valid", 32'(bus.out_rd_valid), 1);
    check("rd_0_0", 32'(bus.out_rd_data[0]), 0);
    check("rd_36_36", 32'(bus.out_rd_data[1]), 72);
    rd(0, 40, 0); rd(1, 0, 36);
    step();
    check("rd_oob_row", 32'(bus.out_rd_data[0]), 0);
    check("rd_0_36", 32'(bus.out_rd_data[1]), 36);
    step();
    check("rd_valid_drop", 32'(bus.out_rd_valid), 0);

    bus.in_freeze = 1'b1;
    step();
    check("frz_frozen", 32'(bus.out_frozen), 1);
    check("frz_fx", 32'(bus.out_feature_x), 82);
    check("frz_fy", 32'(bus.out_feature_y), 50);
    check("frz_accepting", 32'(bus.out_accepting_input), 0);
    check("frz_ready", 32'(bus.out_window_ready), 0);
    load_col(200, 7, 7);
    rd(0, 0, 36); rd(1, 36, 0);
    step();
    check("frz_drop_rd0", 32'(bus.out_rd_data[0]), 36);
    check("frz_drop_rd1", 32'(bus.out_rd_data[1]), 36);
    check("frz_rd_valid", 32'(bus.out_rd_valid), 1);
    check("frz_drop_fill", 32'(bus.out_fill_count), 37);

    bus.in_release = 1'b1;
    step();
    check("rel_frozen", 32'(bus.out_frozen), 0);
    check("rel_ready", 32'(bus.out_window_ready), 1);

    // Column and freeze together: the capture includes the new column.
    load_col(37, 101, 51);
    bus.in_freeze = 1'b1;
    step();
    check("vf_frozen", 32'(bus.out_frozen), 1);
    check("vf_fx", 32'(bus.out_feature_x), 83);
    check("vf_fy", 32'(bus.out_feature_y), 51);
    rd(0, 0, 36); rd(1, 0, 0);
    step();
    check("vf_newcol", 32'(bus.out_rd_data[0]), 37);
    check("vf_col0", 32'(bus.out_rd_data[1]), 1);

    bus.in_freeze = 1'b1; bus.in_release = 1'b1;
    step();
    check("fr_rel_frozen", 32'(bus.out_frozen), 0);
    check("fr_rel_ready", 32'(bus.out_window_ready), 1);

    // Read alongside a transfer sees the pre-shift window.
    load_col(38, 102, 52);
    rd(0, 0, 0); rd(1, 5, 36);
    step();
    check("pre_shift_0_0", 32'(bus.out_rd_data[0]), 1);
    check("pre_shift_5_36", 32'(bus.out_rd_data[1]), 42);
    rd(0, 0, 0); rd(1, 5, 36);
    step();
    check("post_shift_0_0", 32'(bus.out_rd_data[0]), 2);
    check("post_shift_5_36", 32'(bus.out_rd_data[1]), 43);

    bus.in_freeze = 1'b1;
    step();
    check("frz2_fx", 32'(bus.out_feature_x), 84);
    bus.in_flush = 1'b1; bus.in_release = 1'b1;
    load_col(250, 9, 9);
    step();
    check("flush_frozen", 32'(bus.out_frozen), 0);
    check("flush_ready", 32'(bus.out_window_ready), 0);
    check("flush_fill", 32'(bus.out_fill_count), 0);
    check("flush_accepting", 32'(bus.out_accepting_input), 1);
    check("flush_fx_kept", 32'(bus.out_feature_x), 84);
    rd(0, 0, 0);
    step();
    check("flush_rd_valid", 32'(bus.out_rd_valid), 0);
    check("flush_rd_data", 32'(bus.out_rd_data[0]), 0);

    // Freeze on the fill-completing column is ignored.
    fill_window(1'b1);

    load_col(5, 5, 9);
    bus.in_freeze = 1'b1;
    step();
    check("wrap_fx", 32'(bus.out_feature_x), 65523);
    check("wrap_fy", 32'(bus.out_feature_y), 9);

    bus.in_flush = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      load_col(k, k, 3);
      step();
    end
    check("pre_rst_fill", 32'(bus.out_fill_count), 20);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_fill", 32'(bus.out_fill_count), 0);
    check("arst_fx", 32'(bus.out_feature_x), 0);
    check("arst_fy", 32'(bus.out_feature_y), 0);
    check("arst_ready", 32'(bus.out_window_ready), 0);
    check("arst_accepting", 32'(bus.out_accepting_input), 1);
    check("arst_frozen", 32'(bus.out_frozen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_window(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
